// File: rtl/if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : if_stage                                                      |
// | Function : Instruction fetch (PC + IF/ID register) with STOP drain/halt. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          IMEM_AW      = 10,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_en,
  input  logic [31:0]        redirect_pc,
  input  logic               flush,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic               ifid_valid,
  output logic [31:0]        ifid_instr,
  output logic [31:0]        ifid_pc_plus4,
  output logic [5:0]         ifid_opcode,
  output logic [5:0]         ifid_func,
  output logic               halted
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [5:0] c_stop_op      = 6'h3F;
  localparam logic [3:0] c_drain_cycles = 4'(DRAIN_CYCLES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_halted;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;
  logic        w_unused;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused      = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_cnt      <= 4'd0;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_instr    <= 32'h0;
      r_pc_plus4 <= 32'h0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (redirect_en)
            r_pc <= w_redirect_pc;
          else if (!stall)
            r_pc <= w_pc_plus4;

          if (flush) begin
            r_valid    <= 1'b0;
            r_instr    <= 32'h0;
            r_pc_plus4 <= 32'h0;
          end else if (!stall) begin
            r_valid    <= 1'b1;
            r_instr    <= imem_rdata;
            r_pc_plus4 <= w_pc_plus4;
            // STOP enters IF/ID: fetch freezes one word past it
            if (imem_rdata[31:26] == c_stop_op) begin
              r_state <= ST_DRAIN;
              r_cnt   <= 4'd0;
            end
          end
        end

        ST_DRAIN: begin
          if (redirect_en)
            r_pc <= w_redirect_pc;

          if (flush) begin
            // STOP turned out to be wrong-path: resume fetching
            r_valid    <= 1'b0;
            r_instr    <= 32'h0;
            r_pc_plus4 <= 32'h0;
            r_state    <= ST_RUN;
            r_cnt      <= 4'd0;
          end else begin
            if (!stall) begin
              r_valid <= 1'b0;
              r_instr <= 32'h0;
            end
            // DRAIN_CYCLES bubble edges pass before the halting edge
            if (r_cnt == c_drain_cycles) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end

        ST_HALT: begin
          r_valid <= 1'b0;
          r_instr <= 32'h0;
        end

        default: begin
          r_state <= ST_RUN;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign imem_addr     = r_pc[IMEM_AW+1:2];
  assign pc            = r_pc;
  assign ifid_valid    = r_valid;
  assign ifid_instr    = r_instr;
  assign ifid_pc_plus4 = r_pc_plus4;
  assign ifid_opcode   = r_instr[31:26];
  assign ifid_func     = r_instr[5:0];
  assign halted        = r_halted;

endmodule
`default_nettype wire
